ram64_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer in front of one single-port RAM64 (16-bit words, 64 entries, write on `clk` edge when `load`, combinational read). It lets two independent masters share the RAM through a req/ack handshake, registers each granted access, drives the RAM control lines for exactly one cycle, and returns read data on a per-port, held output register. It sits between the RAM64 instance and its two users, with no other logic on the RAM ports.

---
 rtl/ram64_arbiter.sv | 153 +++++++++++++++
 tb/tb_ram64_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram64_arbiter.sv
// ram64_arbiter
// Two-port round-robin arbiter and sequencer in front of a single-port RAM64
// (16-bit words, 64 entries, write on clk edge when load, combinational read).
// Each granted access is registered. The RAM control lines are driven for exactly
// one cycle. Read data comes back on a per-port register that holds its value.
//
// Ports
//   clk, reset            : single clock, synchronous active-high reset
//   req0/req1             : access request per port (held until ack)
//   we0/we1               : 1 = write, 0 = read, sampled with req
//   addr0/addr1 [5:0]     : word address
//   din0/din1   [15:0]    : write data
//   ack0/ack1             : one-cycle completion pulse
//   dout0/dout1 [15:0]    : read data, held until that port's next completed read
//   ram_address/ram_in/ram_load : drive the RAM64 address/in/load pins
//   ram_out [15:0]        : RAM64 out pin
//   busy                  : high whenever the sequencer is not idle
module ram64_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [5:0]  addr0,
    input  logic [5:0]  addr1,
    input  logic [15:0] din0,
    input  logic [15:0] din1,
    output logic        ack0,
    output logic        ack1,
    output logic [15:0] dout0,
    output logic [15:0] dout1,
    output logic [5:0]  ram_address,
    output logic [15:0] ram_in,
    output logic        ram_load,
    input  logic [15:0] ram_out,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic        r_prio;
    logic        r_gnt_id;
    logic        r_we_q;
    logic [5:0]  r_addr_q;
    logic [15:0] r_din_q;
    logic [15:0] r_dout0;
    logic [15:0] r_dout1;

    logic        w_gnt_valid;
    logic        w_gnt_id;
    logic        w_sel_we;
    logic [5:0]  w_sel_addr;
    logic [15:0] w_sel_din;

    // Next-state and grant decision; requests are only looked at in IDLE.
    always_comb begin
        w_next_state = r_state;
        w_gnt_valid  = 1'b0;
        w_gnt_id     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req0 && req1) begin
                    w_gnt_valid = 1'b1;
                    w_gnt_id    = r_prio;
                end else if (req0) begin
                    w_gnt_valid = 1'b1;
                    w_gnt_id    = 1'b0;
                end else if (req1) begin
                    w_gnt_valid = 1'b1;
                    w_gnt_id    = 1'b1;
                end else begin
                    w_gnt_valid = 1'b0;
                    w_gnt_id    = 1'b0;
                end
                if (w_gnt_valid) begin
                    w_next_state = ST_ACCESS;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_ACCESS: w_next_state = ST_DONE;
            ST_DONE:   w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Select the granted port's request fields for latching.
    always_comb begin
        if (w_gnt_id) begin
            w_sel_we   = we1;
            w_sel_addr = addr1;
            w_sel_din  = din1;
        end else begin
            w_sel_we   = we0;
            w_sel_addr = addr0;
            w_sel_din  = din0;
        end
    end

    // State register, request latch, read-data capture and priority update.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_prio   <= 1'b0;
            r_gnt_id <= 1'b0;
            r_we_q   <= 1'b0;
            r_addr_q <= 6'd0;
            r_din_q  <= 16'd0;
            r_dout0  <= 16'd0;
            r_dout1  <= 16'd0;
        end else begin
            r_state <= w_next_state;
            if ((r_state == ST_IDLE) && w_gnt_valid) begin
                r_gnt_id <= w_gnt_id;
                r_we_q   <= w_sel_we;
                r_addr_q <= w_sel_addr;
                r_din_q  <= w_sel_din;
            end
            if (r_state == ST_ACCESS) begin
                if (!r_we_q) begin
                    if (r_gnt_id) begin
                        r_dout1 <= ram_out;
                    end else begin
                        r_dout0 <= ram_out;
                    end
                end
                // Whoever was just served yields priority to the other port.
                r_prio <= ~r_gnt_id;
            end
        end
    end

    // Output decode from registered state. ram_load is also gated by reset so
    // a reset landing in ACCESS suppresses the RAM write in that same cycle.
    always_comb begin
        ack0        = (r_state == ST_DONE) && !r_gnt_id;
        ack1        = (r_state == ST_DONE) &&  r_gnt_id;
        busy        = (r_state != ST_IDLE);
        ram_load    = (r_state == ST_ACCESS) && r_we_q && !reset;
        ram_address = r_addr_q;
        ram_in      = r_din_q;
        dout0       = r_dout0;
        dout1       = r_dout1;
    end

endmodule

// File: tb/tb_ram64_arbiter.sv
// Testbench for ram64_arbiter with a behavioural RAM64 attached.
// Stimulus threads push expected acknowledgements into a scoreboard queue;
// a monitor on the falling edge pops and compares whenever an ack appears.
module tb_ram64_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic        we0 = 1'b0, we1 = 1'b0;
    logic [5:0]  addr0 = 6'd0, addr1 = 6'd0;
    logic [15:0] din0 = 16'd0, din1 = 16'd0;
    logic        ack0, ack1, ram_load, busy;
    logic [15:0] dout0, dout1, ram_in, ram_out;
    logic [5:0]  ram_address;

    ram64_arbiter dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .din0(din0), .din1(din1),
        .ack0(ack0), .ack1(ack1), .dout0(dout0), .dout1(dout1),
        .ram_address(ram_address), .ram_in(ram_in), .ram_load(ram_load),
        .ram_out(ram_out), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural RAM64: synchronous write, combinational read.
    logic [15:0] mem [64];
    initial for (int i = 0; i < 64; i++) mem[i] = 16'd0;
    always @(posedge clk) if (ram_load) mem[ram_address] <= ram_in;
    assign ram_out = mem[ram_address];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        port;
        int          cyc;
        logic [15:0] d0;
        logic [15:0] d1;
    } exp_t;
    exp_t sb[$];

    // Reference model state
    logic [15:0] mem_m [64];
    logic [15:0] dout_m [2];
    logic        prio_m = 1'b0;
    initial begin
        for (int i = 0; i < 64; i++) mem_m[i] = 16'd0;
        dout_m[0] = 16'd0;
        dout_m[1] = 16'd0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every ack must match the head of the scoreboard.
    always @(negedge clk) begin
        if (ack0 || ack1) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", {30'd0, ack1, ack0}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ack_onehot", {30'd0, ack1, ack0}, e.port ? 32'd2 : 32'd1);
                chk("ack_cycle", cyc, e.cyc);
                chk("dout0", {16'd0, dout0}, {16'd0, e.d0});
                chk("dout1", {16'd0, dout1}, {16'd0, e.d1});
            end
        end
    end

    task automatic set_port(input logic p, input logic we, input logic [5:0] a, input logic [15:0] d);
        if (p) begin
            req1 = 1'b1; we1 = we; addr1 = a; din1 = d;
        end else begin
            req0 = 1'b1; we0 = we; addr0 = a; din0 = d;
        end
    endtask

    task automatic drop_req(input logic p);
        if (p) req1 = 1'b0;
        else   req0 = 1'b0;
    endtask

    // Record one granted access in the model and push its expected ack.
    task automatic push_access(input logic p, input logic we, input logic [5:0] a,
                               input logic [15:0] d, input int t);
        exp_t e;
        if (we) mem_m[a] = d;
        else    dout_m[p] = mem_m[a];
        e.port = p; e.cyc = t; e.d0 = dout_m[0]; e.d1 = dout_m[1];
        sb.push_back(e);
        prio_m = ~p;
    endtask

    // Single uncontested access, issued right after a rising edge while idle.
    task automatic single(input logic p, input logic we, input logic [5:0] a,
                          input logic [15:0] d, input logic chk_access);
        int c;
        set_port(p, we, a, d);
        c = cyc;
        push_access(p, we, a, d, c + 2);
        @(posedge clk);
        if (chk_access) begin
            @(negedge clk);
            chk("access_ram_load", {31'd0, ram_load}, {31'd0, we});
            chk("access_ram_address", {26'd0, ram_address}, {26'd0, a});
            chk("access_busy", {31'd0, busy}, 32'd1);
        end
        @(posedge clk);
        @(posedge clk);
        #1 drop_req(p);
    endtask

    // Both ports request together and each is served 'rounds' times.
    task automatic contend(input logic we0_v, input logic [5:0] a0, input logic [15:0] d0,
                           input logic we1_v, input logic [5:0] a1, input logic [15:0] d1,
                           input int rounds);
        int   c;
        logic w;
        set_port(1'b0, we0_v, a0, d0);
        set_port(1'b1, we1_v, a1, d1);
        c = cyc;
        w = prio_m;
        for (int i = 0; i < rounds; i++) begin
            if (w) begin
                push_access(1'b1, we1_v, a1, d1, c + 2 + 6 * i);
                push_access(1'b0, we0_v, a0, d0, c + 5 + 6 * i);
            end else begin
                push_access(1'b0, we0_v, a0, d0, c + 2 + 6 * i);
                push_access(1'b1, we1_v, a1, d1, c + 5 + 6 * i);
            end
        end
        fork
            begin
                repeat (3 + 6 * (rounds - 1)) @(posedge clk);
                #1 drop_req(w);
            end
            begin
                repeat (6 + 6 * (rounds - 1)) @(posedge clk);
                #1 drop_req(~w);
            end
        join
    endtask

    initial begin
        // Reset held for two cycles
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ram_load", {31'd0, ram_load}, 32'd0);
        #4 reset = 1'b0;
        @(negedge clk);
        chk("rst_ack", {30'd0, ack1, ack0}, 32'd0);
        chk("rst_dout0", {16'd0, dout0}, 32'd0);
        chk("rst_dout1", {16'd0, dout1}, 32'd0);
        chk("rst_ram_address", {26'd0, ram_address}, 32'd0);
        chk("rst_ram_in", {16'd0, ram_in}, 32'd0);
        chk("rst_busy2", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;

        // Write then read-back from the other port
        single(1'b0, 1'b1, 6'd5, 16'h1234, 1'b1);
        single(1'b1, 1'b0, 6'd5, 16'h0000, 1'b1);

        // Contention: two writes, then cross read-back
        contend(1'b1, 6'd10, 16'hAAAA, 1'b1, 6'd20, 16'h5555, 1);
        single(1'b0, 1'b0, 6'd20, 16'h0000, 1'b0);
        single(1'b1, 1'b0, 6'd10, 16'h0000, 1'b0);

        // Sustained contention: strict alternation, ack every 3 cycles
        contend(1'b0, 6'd10, 16'h0000, 1'b0, 6'd20, 16'h0000, 2);

        // Boundary addresses from both ports
        single(1'b0, 1'b1, 6'd0,  16'h0001, 1'b0);
        single(1'b1, 1'b1, 6'd63, 16'hBEEF, 1'b1);
        single(1'b1, 1'b0, 6'd0,  16'h0000, 1'b0);
        single(1'b0, 1'b0, 6'd63, 16'h0000, 1'b0);
        single(1'b1, 1'b1, 6'd0,  16'hC0DE, 1'b0);
        single(1'b0, 1'b0, 6'd0,  16'h0000, 1'b0);
        single(1'b1, 1'b0, 6'd63, 16'h0000, 1'b0);

        // Reset landing in the ACCESS cycle of a write to addr 63
        set_port(1'b0, 1'b1, 6'd63, 16'hFFFF);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rstacc_busy", {31'd0, busy}, 32'd1);
        chk("rstacc_ram_load", {31'd0, ram_load}, 32'd0);
        @(posedge clk);
        #1 begin
            reset = 1'b0;
            drop_req(1'b0);
        end
        @(negedge clk);
        chk("rstacc_after_busy", {31'd0, busy}, 32'd0);
        chk("rstacc_after_ack", {30'd0, ack1, ack0}, 32'd0);
        chk("rstacc_after_dout0", {16'd0, dout0}, 32'd0);
        chk("rstacc_after_dout1", {16'd0, dout1}, 32'd0);
        dout_m[0] = 16'd0;
        dout_m[1] = 16'd0;
        prio_m    = 1'b0;
        @(posedge clk); #1;
        single(1'b1, 1'b0, 6'd63, 16'h0000, 1'b0);

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
